// File: rtl/onehot_step_decoder_if.sv
// onehot_step_decoder_if: command/result bundle for the step decoder.
// Groups all non-clock, non-reset signals of onehot_step_decoder.
//
// Ports (signals):
//   en, mode, sel, clr, load, adv : driven by the control unit (master)
//   out, step, wrap, range_err    : driven by the decoder (slave)
interface onehot_step_decoder_if #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
);
  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic               clr;
  logic               load;
  logic               adv;
  logic [NUM_OUT-1:0] out;
  logic [SEL_W-1:0]   step;
  logic               wrap;
  logic               range_err;

  modport master (
    output en, mode, sel, clr, load, adv,
    input  out, step, wrap, range_err
  );

  modport slave (
    input  en, mode, sel, clr, load, adv,
    output out, step, wrap, range_err
  );
endinterface

// File: rtl/onehot_step_decoder.sv
// onehot_step_decoder: registered one-hot decoder / step sequencer.
// Decode mode drives onehot(sel); sequencer mode drives onehot(step).
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : onehot_step_decoder_if.slave
//     en        stall when low (step/out hold, pulses clear)
//     mode      0 = decode, 1 = sequencer
//     sel       decode index or load value
//     clr/load/adv  sequencer commands, priority clr > load > adv
//     out       registered one-hot (all-zero after bad decode)
//     step      registered step counter, always < NUM_OUT
//     wrap      pulse: counter wrapped NUM_OUT-1 -> 0
//     range_err pulse: sel >= NUM_OUT was used
module onehot_step_decoder #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
) (
  input logic                 clk,
  input logic                 reset,
  onehot_step_decoder_if.slave bus
);

  localparam logic [SEL_W:0]   NUM_OUT_C = (SEL_W+1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] LAST_C    = SEL_W'(NUM_OUT - 1);

  logic [SEL_W-1:0]   step_q, step_d;
  logic [NUM_OUT-1:0] out_q,  out_d;
  logic               wrap_q, wrap_d;
  logic               rerr_q, rerr_d;
  logic               sel_ok;

  // Indices at or above NUM_OUT match no bit,
  // so an out-of-range decode yields all-zero.
  function automatic logic [NUM_OUT-1:0] onehot(
    input logic [SEL_W-1:0] idx
  );
    logic [NUM_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (idx == SEL_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Extra bit lets NUM_OUT == 2^SEL_W compare correctly.
  assign sel_ok = ({1'b0, bus.sel} < NUM_OUT_C);

  always_comb begin
    step_d = step_q;
    out_d  = out_q;
    wrap_d = 1'b0;
    rerr_d = 1'b0;
    if (bus.en) begin
      unique case (bus.mode)
        1'b0: begin
          out_d  = onehot(bus.sel);
          rerr_d = ~sel_ok;
        end
        1'b1: begin
          if (bus.clr) begin
            step_d = '0;
          end else if (bus.load) begin
            if (sel_ok) step_d = bus.sel;
            else        rerr_d = 1'b1;
          end else if (bus.adv) begin
            if (step_q == LAST_C) begin
              step_d = '0;
              wrap_d = 1'b1;
            end else begin
              step_d = step_q + 1'b1;
            end
          end
          // Tracks next step so out == onehot(step)
          // on every sequencer cycle.
          out_d = onehot(step_d);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= '0;
      out_q  <= NUM_OUT'(1);
      wrap_q <= 1'b0;
      rerr_q <= 1'b0;
    end else begin
      step_q <= step_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
      rerr_q <= rerr_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.step      = step_q;
  assign bus.wrap      = wrap_q;
  assign bus.range_err = rerr_q;

endmodule
